// File: rtl/lfsr_period_checker.sv
// Locks onto an 8-bit LFSR stream at its seed, flywheels the predicted sequence,
// counts mismatches and measures the number of samples until the seed recurs.
module lfsr_period_checker #(
  parameter int DW    = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [DW-1:0]    seed,
  input  logic [DW-1:0]    din,
  input  logic             din_en,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             period_vld,
  output logic [7:0]       period,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'd254;

  // x^8+x^6+x^5+x^4+1, shifting toward the LSB
  function automatic logic [DW-1:0] nxt(input logic [DW-1:0] x);
    nxt = {x[0] ^ x[2] ^ x[3] ^ x[4], x[DW-1:1]};
  endfunction

  state_t           state_reg, state_next;
  logic [DW-1:0]    seed_reg;
  logic [DW-1:0]    pred_reg;
  logic [7:0]       cnt_reg;
  logic [ERR_W-1:0] err_reg;
  logic [7:0]       period_reg;
  logic             timeout_reg;
  logic             vld_reg;

  logic             hit_seed;
  logic             track_end;

  assign hit_seed  = din_en && (din == seed_reg);
  assign track_end = din_en && ((din == seed_reg) || (cnt_reg == LAST_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // arm restarts the measurement from every state, including mid-run
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arm) state_next = SYNC;
      SYNC:    if (arm) state_next = SYNC;
               else if (hit_seed) state_next = TRACK;
      TRACK:   if (arm) state_next = SYNC;
               else if (track_end) state_next = DONE;
      DONE:    if (arm) state_next = SYNC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    locked = 1'b0;
    done   = 1'b0;
    case (state_reg)
      SYNC:    busy = 1'b1;
      TRACK:   begin
        busy   = 1'b1;
        locked = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_reg    <= '0;
      pred_reg    <= '0;
      cnt_reg     <= '0;
      err_reg     <= '0;
      period_reg  <= '0;
      timeout_reg <= 1'b0;
      vld_reg     <= 1'b0;
    end else begin
      vld_reg <= 1'b0;
      if (arm) begin
        seed_reg    <= seed;
        cnt_reg     <= '0;
        err_reg     <= '0;
        period_reg  <= '0;
        timeout_reg <= 1'b0;
      end else if (state_reg == SYNC) begin
        if (hit_seed) begin
          pred_reg <= nxt(din);
          cnt_reg  <= '0;
        end
      end else if (state_reg == TRACK && din_en) begin
        if (din != pred_reg && !(&err_reg)) begin
          err_reg <= err_reg + ERR_W'(1);
        end
        // prediction free-runs; a corrupted sample never pulls the phase
        pred_reg <= nxt(pred_reg);
        if (din == seed_reg) begin
          period_reg <= cnt_reg + 8'd1;
          vld_reg    <= 1'b1;
        end else if (cnt_reg == LAST_CNT) begin
          timeout_reg <= 1'b1;
          vld_reg     <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  end

  assign period_vld = vld_reg;
  assign period     = period_reg;
  assign timeout    = timeout_reg;
  assign err_cnt    = err_reg;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed and randomized runs of lfsr_period_checker against a queue-based
// model that derives lock point, end point, period and error count from the stream.
module tb_lfsr_period_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [7:0] seed;
  logic [7:0] din;
  logic       din_en;
  logic       busy;
  logic       locked;
  logic       done;
  logic       period_vld;
  logic [7:0] period;
  logic       timeout;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] sd [0:1023];
  logic       se [0:1023];
  int         slen;

  always #5 clk = ~clk;

  lfsr_period_checker #(.DW(8), .ERR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .seed       (seed),
    .din        (din),
    .din_en     (din_en),
    .busy       (busy),
    .locked     (locked),
    .done       (done),
    .period_vld (period_vld),
    .period     (period),
    .timeout    (timeout),
    .err_cnt    (err_cnt)
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[4], x[7:1]};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 = din_en always 1, 1 = alternating, 2 = random 75% duty
  task automatic build(input logic [7:0] s, input int junk, input int gap,
                       input int cpos, input logic [7:0] cmask);
    logic [7:0] v;
    int  k;
    bit  tog;
    bit  en;
    v = s;
    k = 0;
    tog = 1'b1;
    slen = 0;
    for (int i = 0; i < junk; i++) begin
      sd[slen] = 8'($urandom);
      se[slen] = 1'b1;
      slen++;
    end
    while (k <= 256) begin
      if (gap == 1) begin
        en = tog;
        tog = !tog;
      end else if (gap == 2) begin
        en = ($urandom_range(0, 3) != 0);
      end else begin
        en = 1'b1;
      end
      se[slen] = en;
      if (en) begin
        sd[slen] = (k == cpos) ? (v ^ cmask) : v;
        v = nxt(v);
        k++;
      end else begin
        sd[slen] = (slen > 0) ? sd[slen-1] : 8'h00;
      end
      slen++;
    end
  endtask

  task automatic build_timeout(input logic [7:0] s);
    sd[0] = s;
    se[0] = 1'b1;
    for (int i = 1; i < 300; i++) begin
      sd[i] = 8'h00;
      se[i] = 1'b1;
    end
    slen = 300;
  endtask

  // Expected outcome: the j-th valid sample after the lock should equal nxt^j(seed)
  task automatic model(input logic [7:0] s, output int lk, output int endi,
                       output int per, output int to, output int err);
    int idx[$];
    logic [7:0] p;
    lk = -1; endi = -1; per = 0; to = 0; err = 0;
    for (int i = 0; i < slen; i++) begin
      if (se[i] && sd[i] == s) begin
        lk = i;
        break;
      end
    end
    if (lk < 0) return;
    for (int i = lk + 1; i < slen; i++) if (se[i]) idx.push_back(i);
    p = s;
    for (int j = 1; j <= 255 && j <= idx.size(); j++) begin
      p = nxt(p);
      if (sd[idx[j-1]] != p) err++;
      if (sd[idx[j-1]] == s) begin
        per = j;
        endi = idx[j-1];
        break;
      end
      if (j == 255) begin
        to = 1;
        endi = idx[j-1];
      end
    end
    if (err > 255) err = 255;
  endtask

  task automatic drive(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      din_en = se[i];
      din    = sd[i];
      tick();
    end
    din_en = 1'b0;
  endtask

  task automatic run(input string name, input logic [7:0] s);
    int lk_e, end_e, per_e, to_e, err_e;
    int lk_o, end_o, vld_n;
    lk_o = -1; end_o = -1; vld_n = 0;
    model(s, lk_e, end_e, per_e, to_e, err_e);
    arm = 1'b1;
    seed = s;
    din_en = 1'b0;
    tick();
    arm = 1'b0;
    chk({name, " busy_at_arm"}, int'(busy), 1);
    chk({name, " locked_at_arm"}, int'(locked), 0);
    chk({name, " cleared_err"}, int'(err_cnt), 0);
    chk({name, " cleared_period"}, int'(period), 0);
    chk({name, " cleared_timeout"}, int'(timeout), 0);
    for (int i = 0; i < slen && end_o < 0; i++) begin
      din_en = se[i];
      din    = sd[i];
      tick();
      if (locked && lk_o < 0) lk_o = i;
      if (period_vld) vld_n++;
      if (done) end_o = i;
    end
    din_en = 1'b0;
    tick();
    if (period_vld) vld_n++;
    chk({name, " lock_index"}, lk_o, lk_e);
    chk({name, " done_index"}, end_o, end_e);
    chk({name, " period"}, int'(period), per_e);
    chk({name, " timeout"}, int'(timeout), to_e);
    chk({name, " err_cnt"}, int'(err_cnt), err_e);
    chk({name, " vld_cycles"}, vld_n, 1);
    chk({name, " done_hold"}, int'(done), 1);
    chk({name, " busy_after"}, int'(busy), 0);
    $display("run %s seed=%02h lock=%0d done_at=%0d period=%0d err=%0d timeout=%0d",
             name, s, lk_o, end_o, period, err_cnt, timeout);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vld_n;
    logic [7:0] rs;
    int cp;
    rst = 1'b1; arm = 1'b0; din_en = 1'b0; seed = 8'h00; din = 8'h00;
    tick();
    arm = 1'b1; seed = 8'h11;
    tick();
    arm = 1'b0;
    chk("reset outputs", int'({busy, locked, done, period_vld, period, timeout, err_cnt}), 0);
    rst = 1'b0;
    tick();
    chk("idle busy", int'(busy), 0);
    $display("reset check done");

    build(8'h01, 0, 0, -1, 8'h00);
    run("nominal", 8'h01);
    build(8'h00, 0, 0, -1, 8'h00);
    run("zero_seed", 8'h00);
    build(8'h01, 0, 0, 10, 8'h04);
    run("corrupt10", 8'h01);
    build(8'h01, 0, 1, -1, 8'h00);
    run("gapped", 8'h01);
    build_timeout(8'h55);
    run("timeout", 8'h55);

    for (int r = 0; r < 4; r++) begin
      rs = 8'($urandom_range(1, 255));
      cp = $urandom_range(1, 300);
      build(rs, $urandom_range(0, 20), 2, cp, 8'($urandom_range(1, 255)));
      run("random", rs);
    end

    // abort a seed-0x01 run mid-TRACK by re-arming with seed 0x02
    build(8'h01, 0, 0, 5, 8'h01);
    arm = 1'b1; seed = 8'h01;
    tick();
    arm = 1'b0;
    drive(0, 20);
    chk("abort pre locked", int'(locked), 1);
    chk("abort pre err", int'(err_cnt), 1);
    $display("abort mid-track locked=%0d err=%0d", locked, err_cnt);
    build(8'h02, 3, 0, -1, 8'h00);
    run("abort_rearm", 8'h02);

    // reset mid-TRACK
    build(8'h01, 0, 0, -1, 8'h00);
    arm = 1'b1; seed = 8'h01;
    tick();
    arm = 1'b0;
    drive(0, 30);
    chk("midrun locked", int'(locked), 1);
    rst = 1'b1;
    din_en = se[30];
    din = sd[30];
    tick();
    chk("midrun reset outputs", int'({busy, locked, done, period_vld, period, timeout, err_cnt}), 0);
    rst = 1'b0;
    vld_n = 0;
    for (int i = 31; i < slen; i++) begin
      din_en = se[i];
      din    = sd[i];
      tick();
      if (period_vld) vld_n++;
    end
    din_en = 1'b0;
    chk("midrun no vld", vld_n, 0);
    chk("midrun idle", int'(busy | done), 0);
    $display("reset mid-track vld_pulses=%0d busy=%0d done=%0d", vld_n, busy, done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
